// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and default geometry for the LED scan controller
package scan_pkg;

  typedef enum logic [1:0] {
    S_RRST  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } scan_state_e;

  localparam int COLS         = 64;
  localparam int ROW_BITS     = 4;
  localparam int PWM_STEPS    = 31;
  localparam int BLANK_CYCLES = 4;

endpackage

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - HUB75 panel scan and AL422 read sequencing behind the RGB555 receiver
module led_scan_ctrl #(
  parameter int COLS         = scan_pkg::COLS,
  parameter int ROW_BITS     = scan_pkg::ROW_BITS,
  parameter int PWM_STEPS    = scan_pkg::PWM_STEPS,
  parameter int BLANK_CYCLES = scan_pkg::BLANK_CYCLES
) (
  input  logic                in_clk,
  input  logic                in_nrst,
  input  logic                led_clk,
  input  logic                pwm_cntr_strobe,
  input  logic                alrst_strobe,
  input  logic [2:0]          rgb1_in,
  input  logic [2:0]          rgb2_in,
  output logic [7:0]          pwm_value,
  output logic                panel_clk,
  output logic [2:0]          panel_rgb1,
  output logic [2:0]          panel_rgb2,
  output logic                panel_lat,
  output logic                panel_oe_n,
  output logic [ROW_BITS-1:0] panel_row,
  output logic                al_re_n,
  output logic                al_rrst_n
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PWM_W = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
  localparam int BLK_W = $clog2(BLANK_CYCLES);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_STEPS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);

  typedef scan_pkg::scan_state_e state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [BLK_W-1:0]    blank_q, blank_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PWM_W-1:0]    pwm_q, pwm_d;
  logic [1:0]          rrst_cnt_q, rrst_cnt_d;
  logic                clk_q, clk_d;
  logic                lat_q, lat_d;
  logic                oe_n_q, oe_n_d;
  logic                re_n_q, re_n_d;
  logic                rrst_n_q, rrst_n_d;
  logic [2:0]          rgb1_q, rgb1_d;
  logic [2:0]          rgb2_q, rgb2_d;

  always_ff @(posedge in_clk) begin
    if (!in_nrst) begin
      state_q    <= scan_pkg::S_RRST;
      col_q      <= '0;
      blank_q    <= '0;
      row_q      <= '0;
      pwm_q      <= '0;
      rrst_cnt_q <= '0;
      clk_q      <= 1'b0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      re_n_q     <= 1'b1;
      rrst_n_q   <= 1'b1;
      rgb1_q     <= '0;
      rgb2_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      blank_q    <= blank_d;
      row_q      <= row_d;
      pwm_q      <= pwm_d;
      rrst_cnt_q <= rrst_cnt_d;
      clk_q      <= clk_d;
      lat_q      <= lat_d;
      oe_n_q     <= oe_n_d;
      re_n_q     <= re_n_d;
      rrst_n_q   <= rrst_n_d;
      rgb1_q     <= rgb1_d;
      rgb2_q     <= rgb2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    blank_d    = blank_q;
    row_d      = row_q;
    pwm_d      = pwm_q;
    rrst_cnt_d = rrst_cnt_q;
    clk_d      = 1'b0;
    lat_d      = 1'b0;
    oe_n_d     = oe_n_q;
    re_n_d     = re_n_q;
    rrst_n_d   = rrst_n_q;
    rgb1_d     = rgb1_q;
    rgb2_d     = rgb2_q;

    unique case (state_q)
      scan_pkg::S_RRST: begin
        oe_n_d = 1'b1;
        re_n_d = 1'b1;
        // Read-reset pulse is two cycles wide, then one idle cycle before reads resume.
        case (rrst_cnt_q)
          2'd0: begin
            if (alrst_strobe) begin
              rrst_n_d   = 1'b0;
              rrst_cnt_d = 2'd1;
            end
          end
          2'd1: rrst_cnt_d = 2'd2;
          2'd2: begin
            rrst_n_d   = 1'b1;
            rrst_cnt_d = 2'd3;
          end
          default: begin
            re_n_d     = 1'b0;
            col_d      = '0;
            rrst_cnt_d = 2'd0;
            state_d    = scan_pkg::S_SHIFT;
          end
        endcase
      end

      scan_pkg::S_SHIFT: begin
        clk_d  = led_clk;
        oe_n_d = 1'b0;
        if (led_clk) begin
          rgb1_d = rgb1_in;
          rgb2_d = rgb2_in;
        end
        if (pwm_cntr_strobe) begin
          if (col_q == COL_LAST) begin
            // Blank together with the read stop so the latch window is fully dark.
            col_d   = '0;
            re_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            blank_d = '0;
            state_d = scan_pkg::S_LATCH;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      scan_pkg::S_LATCH: begin
        oe_n_d = 1'b1;
        lat_d  = (blank_q == BLK_W'(0));
        if (blank_q == BLK_W'(1)) begin
          row_d = row_q + ROW_BITS'(1);
        end
        if (blank_q == BLK_LAST) begin
          blank_d = '0;
          if (row_q == '0) begin
            pwm_d   = (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_W'(1);
            state_d = scan_pkg::S_RRST;
          end else begin
            re_n_d  = 1'b0;
            state_d = scan_pkg::S_SHIFT;
          end
        end else begin
          blank_d = blank_q + BLK_W'(1);
        end
      end

      default: state_d = scan_pkg::S_RRST;
    endcase
  end

  assign pwm_value  = 8'(pwm_q);
  assign panel_clk  = clk_q;
  assign panel_rgb1 = rgb1_q;
  assign panel_rgb2 = rgb2_q;
  assign panel_lat  = lat_q;
  assign panel_oe_n = oe_n_q;
  assign panel_row  = row_q;
  assign al_re_n    = re_n_q;
  assign al_rrst_n  = rrst_n_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb/tb_led_scan_ctrl.sv - directed self-checking bench for led_scan_ctrl
module tb_led_scan_ctrl;

  logic       in_clk = 1'b0;
  logic       in_nrst;
  logic       led_clk;
  logic       pwm_cntr_strobe;
  logic       alrst_strobe;
  logic [2:0] rgb1_in;
  logic [2:0] rgb2_in;
  logic [7:0] pwm_value;
  logic       panel_clk;
  logic [2:0] panel_rgb1;
  logic [2:0] panel_rgb2;
  logic       panel_lat;
  logic       panel_oe_n;
  logic [3:0] panel_row;
  logic       al_re_n;
  logic       al_rrst_n;

  always #5 in_clk = ~in_clk;

  led_scan_ctrl dut (
    .in_clk          (in_clk),
    .in_nrst         (in_nrst),
    .led_clk         (led_clk),
    .pwm_cntr_strobe (pwm_cntr_strobe),
    .alrst_strobe    (alrst_strobe),
    .rgb1_in         (rgb1_in),
    .rgb2_in         (rgb2_in),
    .pwm_value       (pwm_value),
    .panel_clk       (panel_clk),
    .panel_rgb1      (panel_rgb1),
    .panel_rgb2      (panel_rgb2),
    .panel_lat       (panel_lat),
    .panel_oe_n      (panel_oe_n),
    .panel_row       (panel_row),
    .al_re_n         (al_re_n),
    .al_rrst_n       (al_rrst_n)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic       ph;
  int         cyc_n, first_strobe;
  int         clk_rises, lat_pulses, lat_cycles, rrst_falls, viol;
  logic       prev_clk, prev_lat, prev_oe_n, prev_rrst_n;
  logic [3:0] prev_row;

  // Drive one cycle of alternating receiver phases, then observe at the falling edge.
  task automatic cyc();
    cyc_n++;
    led_clk         = in_nrst && !ph;
    pwm_cntr_strobe = in_nrst && ph;
    alrst_strobe    = in_nrst && !ph;
    if (alrst_strobe && first_strobe == 0) first_strobe = cyc_n;
    @(negedge in_clk);
    if (in_nrst) begin
      ph = ~ph;
      if (panel_clk && !prev_clk) clk_rises++;
      if (panel_lat && !prev_lat) lat_pulses++;
      if (panel_lat) lat_cycles++;
      if (!al_rrst_n && prev_rrst_n) rrst_falls++;
      if (panel_lat && !panel_oe_n) viol++;
      if (panel_row != prev_row && (!panel_oe_n || !prev_oe_n)) viol++;
      if (pwm_value[7:5] != 3'b000) viol++;
    end
    prev_clk    = panel_clk;
    prev_lat    = panel_lat;
    prev_oe_n   = panel_oe_n;
    prev_rrst_n = al_rrst_n;
    prev_row    = panel_row;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_pwm"},   32'(pwm_value),  32'd0);
    check({pfx, "_row"},   32'(panel_row),  32'd0);
    check({pfx, "_clk"},   32'(panel_clk),  32'd0);
    check({pfx, "_lat"},   32'(panel_lat),  32'd0);
    check({pfx, "_oe_n"},  32'(panel_oe_n), 32'd1);
    check({pfx, "_re_n"},  32'(al_re_n),    32'd1);
    check({pfx, "_rrst_n"},32'(al_rrst_n),  32'd1);
    check({pfx, "_rgb1"},  32'(panel_rgb1), 32'd0);
    check({pfx, "_rgb2"},  32'(panel_rgb2), 32'd0);
  endtask

  initial begin
    int n;
    int w;
    logic [7:0] p0;
    in_nrst = 1'b0;
    ph = 1'b0;
    led_clk = 1'b0;
    pwm_cntr_strobe = 1'b0;
    alrst_strobe = 1'b0;
    rgb1_in = 3'b000;
    rgb2_in = 3'b000;
    cyc_n = 0; first_strobe = 0;
    clk_rises = 0; lat_pulses = 0; lat_cycles = 0; rrst_falls = 0; viol = 0;
    prev_clk = 1'b0; prev_lat = 1'b0; prev_oe_n = 1'b1; prev_rrst_n = 1'b1; prev_row = 4'd0;

    @(negedge in_clk);
    repeat (3) cyc();
    check_reset_outputs("rst");

    in_nrst = 1'b1;
    ph = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (al_rrst_n && n < 20);
    check("rrst_low_seen", 32'(al_rrst_n), 32'd0);
    check("rrst_after_strobe", cyc_n - first_strobe, 0);
    w = 0;
    while (!al_rrst_n && w < 10) begin w++; cyc(); end
    check("rrst_width", w, 2);
    check("re_n_at_rrst_release", 32'(al_re_n), 32'd1);
    cyc();
    check("re_n_after_rrst", 32'(al_re_n), 32'd0);

    clk_rises = 0;
    rgb1_in = 3'b101;
    rgb2_in = 3'b010;
    cyc();
    check("rgb1_latency", 32'(panel_rgb1), 32'h5);
    check("rgb2_latency", 32'(panel_rgb2), 32'h2);
    check("rgb_with_clk", 32'(panel_clk), 32'd1);
    check("oe_n_in_shift", 32'(panel_oe_n), 32'd0);
    rgb1_in = 3'b000;
    rgb2_in = 3'b000;

    n = 0;
    while (!al_re_n && n < 400) begin cyc(); n++; end
    check("row0_clk_pulses", clk_rises, 64);
    check("row0_re_n_stop", 32'(al_re_n), 32'd1);
    check("row0_row_hold", 32'(panel_row), 32'd0);

    lat_pulses = 0;
    lat_cycles = 0;
    n = 0;
    while (al_re_n && n < 20) begin cyc(); n++; end
    check("latch0_pulses", lat_pulses, 1);
    check("latch0_width", lat_cycles, 1);
    check("latch0_row", 32'(panel_row), 32'd1);
    check("latch0_re_n_resume", 32'(al_re_n), 32'd0);

    n = 0;
    while (rrst_falls < 2 && n < 3000) begin cyc(); n++; end
    check("frame_rrst_count", rrst_falls, 2);
    check("frame_row_wrap", 32'(panel_row), 32'd0);
    check("frame_pwm", 32'(pwm_value), 32'd1);
    check("frame_latches", lat_pulses, 16);
    check("frame_latch_cycles", lat_cycles, 16);

    for (int k = 2; k <= 34; k++) begin
      p0 = pwm_value;
      n = 0;
      while (pwm_value == p0 && n < 2500) begin cyc(); n++; end
      check("pwm_step", pwm_value, k % 31);
    end

    n = 0;
    while (!(panel_row == 4'd5 && !al_re_n) && n < 2000) begin cyc(); n++; end
    check("mid_pre_row", 32'(panel_row), 32'd5);
    check("mid_pre_pwm", 32'(pwm_value), 32'd3);
    repeat (40) cyc();
    check("mid_pre_oe_n", 32'(panel_oe_n), 32'd0);
    check("mid_pre_re_n", 32'(al_re_n), 32'd0);
    in_nrst = 1'b0;
    cyc();
    check_reset_outputs("mid");

    in_nrst = 1'b1;
    ph = 1'b0;
    rrst_falls = 0;
    n = 0;
    while (al_re_n && n < 50) begin cyc(); n++; end
    check("restart_rrst", rrst_falls, 1);
    check("restart_re_n", 32'(al_re_n), 32'd0);
    check("restart_row", 32'(panel_row), 32'd0);
    check("restart_pwm", 32'(pwm_value), 32'd0);
    clk_rises = 0;
    n = 0;
    while (!al_re_n && n < 400) begin cyc(); n++; end
    check("restart_clk_pulses", clk_rises, 64);
    n = 0;
    while (al_re_n && n < 20) begin cyc(); n++; end
    check("restart_row_next", 32'(panel_row), 32'd1);
    check("restart_pwm_hold", 32'(pwm_value), 32'd0);

    check("blanking_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
